cpu_mem_arbiter: RTL

//  Shares one memory request/response port between the turbo CPU's instruction-fetch and data-access channels.

---
 rtl/cpu_mem_arb_pkg.sv | 18 +
 rtl/arb_tag_fifo.sv | 58 +++++
 rtl/cpu_mem_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arb_pkg.sv
// rtl/cpu_mem_arb_pkg.sv - shared encodings and widths for the CPU memory arbiter
package cpu_mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Owner tag recorded for every issued read
    localparam logic TAG_INST = 1'b0;
    localparam logic TAG_DATA = 1'b1;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_e;

endpackage

// File: rtl/arb_tag_fifo.sv
// rtl/arb_tag_fifo.sv - 1-bit owner-tag FIFO tracking reads in flight
module arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Tag storage needs no reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - fetch/data arbiter onto one memory port; ARB_PERF_CNT_EN adds perf counters
module cpu_mem_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    output logic [DATA_W-1:0] i_rsp_data,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_wr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [STRB_W-1:0] d_req_strb,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [ADDR_W-1:0] Address,
    output logic              MemWrite,
    output logic [DATA_W-1:0] Write_data,
    output logic [STRB_W-1:0] Write_strb,
    output logic              MemRead,
    input  logic              Mem_Req_Ready,
    input  logic [DATA_W-1:0] Read_data,
    input  logic              Read_data_Valid,
    output logic              Read_data_Ready
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       arb_i_wait_cnt,
    output logic [31:0]       arb_d_wait_cnt,
    output logic [31:0]       arb_orphan_cnt
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    lock_e         lock, lock_nxt;
    logic [SW-1:0] starve_cnt;
    logic          sel_inst;
    logic          sel_valid;
    logic          sel_read;
    logic          issue;
    logic          accept;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_head;
    logic          fifo_push;
    logic          fifo_pop;
    logic          orphan;

    // Lock register: remembers a presented-but-unaccepted request owner
    always_ff @(posedge clk) begin
        if (rst) begin
            lock <= LOCK_NONE;
        end else begin
            lock <= lock_nxt;
        end
    end

    // Grant selection, downstream drive, handshakes and response routing
    always_comb begin
        sel_inst        = 1'b0;
        lock_nxt        = LOCK_NONE;
        Address         = d_req_addr;
        Write_data      = '0;
        Write_strb      = '0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        i_req_ready     = 1'b0;
        d_req_ready     = 1'b0;
        i_rsp_valid     = 1'b0;
        d_rsp_valid     = 1'b0;
        Read_data_Ready = 1'b0;

        case (lock)
            LOCK_INST: sel_inst = 1'b1;
            LOCK_DATA: sel_inst = 1'b0;
            default:   sel_inst = !(d_req_valid &&
                                    !(starve_cnt == STARVE_MAX && i_req_valid)) && i_req_valid;
        endcase

        sel_valid = sel_inst ? i_req_valid : d_req_valid;
        sel_read  = sel_inst || !d_req_wr;
        // A full tag FIFO blocks reads even if a pop happens this cycle
        issue     = sel_valid && !(sel_read && fifo_full);
        accept    = issue && Mem_Req_Ready;

        if (sel_inst) begin
            Address = i_req_addr;
        end
        MemRead  = issue && sel_read;
        MemWrite = issue && !sel_read;
        if (MemWrite) begin
            Write_data = d_req_wdata;
            Write_strb = d_req_strb;
        end
        i_req_ready = accept && sel_inst;
        d_req_ready = accept && !sel_inst;

        if (issue && !Mem_Req_Ready) begin
            lock_nxt = sel_inst ? LOCK_INST : LOCK_DATA;
        end

        if (!fifo_empty) begin
            if (fifo_head == TAG_INST) begin
                i_rsp_valid     = Read_data_Valid;
                Read_data_Ready = i_rsp_ready;
            end else begin
                d_rsp_valid     = Read_data_Valid;
                Read_data_Ready = d_rsp_ready;
            end
        end
    end

    assign i_rsp_data = Read_data;
    assign d_rsp_data = Read_data;
    assign fifo_push  = accept && MemRead;
    assign fifo_pop   = Read_data_Valid && Read_data_Ready;
    assign orphan     = Read_data_Valid && fifo_empty;

    // Count data wins that happen while fetch is waiting; fetch win clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (accept) begin
            if (sel_inst) begin
                starve_cnt <= '0;
            end else if (i_req_valid && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    arb_tag_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_tag (sel_inst ? TAG_INST : TAG_DATA),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

`ifdef ARB_PERF_CNT_EN
    // Free-running wait and orphan counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_i_wait_cnt <= '0;
            arb_d_wait_cnt <= '0;
            arb_orphan_cnt <= '0;
        end else begin
            if (i_req_valid && !i_req_ready) arb_i_wait_cnt <= arb_i_wait_cnt + 1'b1;
            if (d_req_valid && !d_req_ready) arb_d_wait_cnt <= arb_d_wait_cnt + 1'b1;
            if (orphan)                      arb_orphan_cnt <= arb_orphan_cnt + 1'b1;
        end
    end
`else
    logic unused_orphan;
    assign unused_orphan = orphan;
`endif

endmodule
